// File: rtl/axi_err_responder_if.sv
// AXI4 bus bundle for the default/error slave: AW, W, B, AR and R channels.
// The slave modport is the responder side; master is the initiator side.
interface axi_err_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [ID_WIDTH-1:0]     awid;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;

  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;

  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic [ID_WIDTH-1:0]     bid;

  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [ID_WIDTH-1:0]     arid;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;

  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic [ID_WIDTH-1:0]     rid;

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    input  rready,
    output awready, wready, bvalid, bresp, bid,
    output arready, rvalid, rdata, rresp, rlast, rid
  );

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    output rready,
    input  awready, wready, bvalid, bresp, bid,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/axi_err_responder.sv
// AXI4 default slave: completes every transaction with a fixed error response.
// Independent read and write FSMs, one outstanding transaction per direction.
module axi_err_responder #(
  parameter int                   ADDR_WIDTH = 32,
  parameter int                   DATA_WIDTH = 32,
  parameter int                   ID_WIDTH   = 4,
  parameter logic [1:0]           ERR_RESP   = 2'b11,
  parameter logic [DATA_WIDTH-1:0] FILL_DATA = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  axi_err_responder_if.slave    bus,
  output logic                  o_wlast_err,
  output logic [ADDR_WIDTH-1:0] o_last_addr
);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [1:0]          w_state, w_next;
  logic                awready_q;
  logic [ID_WIDTH-1:0] bid_q;
  logic [7:0]          awlen_q, wcnt;
  logic                aw_hs, w_hs, w_end, b_hs, wcnt_at_len;

  logic [0:0]          r_state, r_next;
  logic                arready_q;
  logic [ID_WIDTH-1:0] rid_q;
  logic [7:0]          arlen_q, rcnt;
  logic                ar_hs, r_hs, rlast_int;

  // Write path
  assign aw_hs       = bus.awvalid & awready_q;
  assign w_hs        = bus.wvalid & bus.wready;
  assign wcnt_at_len = (wcnt == awlen_q);
  assign w_end       = w_hs & (bus.wlast | wcnt_at_len);
  assign b_hs        = bus.bvalid & bus.bready;

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_end) w_next = W_RESP;
      W_RESP:  if (b_hs)  w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // awready is a flop so it stays low through reset and rises one edge after release
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b0;
      bid_q     <= '0;
      awlen_q   <= '0;
      wcnt      <= '0;
    end else begin
      w_state   <= w_next;
      awready_q <= (w_next == W_IDLE);
      if (aw_hs) begin
        bid_q   <= bus.awid;
        awlen_q <= bus.awlen;
        wcnt    <= '0;
      end else if (w_hs) begin
        wcnt    <= wcnt + 8'd1;
      end
    end
  end

  assign bus.awready = awready_q;
  assign bus.wready  = (w_state == W_DATA);
  assign bus.bvalid  = (w_state == W_RESP);
  assign bus.bresp   = bus.bvalid ? ERR_RESP : 2'b00;
  assign bus.bid     = bid_q;
  assign o_wlast_err = w_end & (bus.wlast ^ wcnt_at_len);

  // Read path
  assign ar_hs     = bus.arvalid & arready_q;
  assign r_hs      = bus.rvalid & bus.rready;
  assign rlast_int = (r_state == R_DATA) & (rcnt == arlen_q);

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs && rlast_int) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b0;
      rid_q     <= '0;
      arlen_q   <= '0;
      rcnt      <= '0;
    end else begin
      r_state   <= r_next;
      arready_q <= (r_next == R_IDLE);
      if (ar_hs) begin
        rid_q   <= bus.arid;
        arlen_q <= bus.arlen;
        rcnt    <= '0;
      end else if (r_hs) begin
        rcnt    <= rcnt + 8'd1;
      end
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = (r_state == R_DATA);
  assign bus.rdata   = bus.rvalid ? FILL_DATA : '0;
  assign bus.rresp   = bus.rvalid ? ERR_RESP : 2'b00;
  assign bus.rlast   = rlast_int;
  assign bus.rid     = rid_q;

  // Debug capture; a read accepted in the same cycle as a write takes priority
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_last_addr <= '0;
    end else if (ar_hs) begin
      o_last_addr <= bus.araddr;
    end else if (aw_hs) begin
      o_last_addr <= bus.awaddr;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{bus.awsize, bus.awburst, bus.arsize, bus.arburst,
                           bus.wdata, bus.wstrb};

endmodule

// File: tb/tb_axi_err_responder.sv
// Directed bench for axi_err_responder: inputs change and outputs are sampled
// on the falling edge, handshakes complete on the following rising edge.
module tb_axi_err_responder;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wlast_err;
  logic [AW-1:0] last_addr;
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  axi_err_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi_err_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .bus         (bus),
    .o_wlast_err (wlast_err),
    .o_last_addr (last_addr)
  );

  task automatic idle_inputs();
    bus.awvalid = 0; bus.awaddr = '0; bus.awid = '0; bus.awlen = '0;
    bus.awsize = 3'd2; bus.awburst = 2'b01;
    bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '1; bus.wlast = 0;
    bus.bready = 0;
    bus.arvalid = 0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0;
    bus.arsize = 3'd2; bus.arburst = 2'b01;
    bus.rready = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if ({bus.awready, bus.arready, bus.bvalid, bus.rvalid, bus.wready} !== 5'b0) begin
      n_err++; $display("FAIL rst_ctrl: got %b want 00000", {bus.awready, bus.arready, bus.bvalid, bus.rvalid, bus.wready}); end
    n_cmp++; if ({bus.bresp, bus.rresp, bus.rlast, wlast_err} !== 6'b0) begin
      n_err++; $display("FAIL rst_resp: got %b want 000000", {bus.bresp, bus.rresp, bus.rlast, wlast_err}); end
    n_cmp++; if (last_addr !== '0) begin n_err++; $display("FAIL rst_addr: got %0h want 0", last_addr); end
    rst = 0;
    #1;
    n_cmp++; if (bus.awready !== 1'b0) begin n_err++; $display("FAIL rst_rel_awready: got %b want 0", bus.awready); end
    @(negedge clk);
    n_cmp++; if ({bus.awready, bus.arready} !== 2'b11) begin
      n_err++; $display("FAIL rst_ready_rise: got %b want 11", {bus.awready, bus.arready}); end
  endtask

  task automatic test_write_single();
    bus.awvalid = 1; bus.awid = 4'd3; bus.awlen = 8'd0; bus.awaddr = 32'h1000_0040; bus.bready = 1;
    @(negedge clk);
    bus.awvalid = 0;
    n_cmp++; if ({bus.wready, bus.awready} !== 2'b10) begin
      n_err++; $display("FAIL wr1_wready: got %b want 10", {bus.wready, bus.awready}); end
    n_cmp++; if (last_addr !== 32'h1000_0040) begin n_err++; $display("FAIL wr1_addr: got %0h want 10000040", last_addr); end
    bus.wvalid = 1; bus.wlast = 1;
    #1;
    n_cmp++; if (wlast_err !== 1'b0) begin n_err++; $display("FAIL wr1_wlast_err: got %b want 0", wlast_err); end
    @(negedge clk);
    bus.wvalid = 0; bus.wlast = 0;
    n_cmp++; if ({bus.bvalid, bus.bresp, bus.bid} !== {1'b1, 2'b11, 4'd3}) begin
      n_err++; $display("FAIL wr1_b: got %b/%b/%0d want 1/11/3", bus.bvalid, bus.bresp, bus.bid); end
    @(negedge clk);
    n_cmp++; if ({bus.bvalid, bus.awready} !== 2'b01) begin
      n_err++; $display("FAIL wr1_done: got %b want 01", {bus.bvalid, bus.awready}); end
  endtask

  task automatic test_read_burst();
    bus.arvalid = 1; bus.arid = 4'd5; bus.arlen = 8'd3; bus.araddr = 32'h2000_0000; bus.rready = 1;
    @(negedge clk);
    bus.arvalid = 0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({bus.rvalid, bus.rid, bus.rresp, bus.rlast} !== {1'b1, 4'd5, 2'b11, (i == 3)}) begin
        n_err++; $display("FAIL rd_beat%0d: got v=%b id=%0d resp=%b last=%b want 1/5/11/%0d", i, bus.rvalid, bus.rid, bus.rresp, bus.rlast, (i == 3)); end
      n_cmp++; if (bus.rdata !== 32'h0) begin n_err++; $display("FAIL rd_data%0d: got %0h want 0", i, bus.rdata); end
      @(negedge clk);
    end
    n_cmp++; if ({bus.rvalid, bus.arready} !== 2'b01) begin
      n_err++; $display("FAIL rd_end: got %b want 01", {bus.rvalid, bus.arready}); end
  endtask

  task automatic test_backpressure();
    int beats = 0;
    bus.arvalid = 1; bus.arid = 4'd2; bus.arlen = 8'd1; bus.rready = 0;
    @(negedge clk);
    bus.arvalid = 0;
    for (int k = 0; k < 6; k++) begin
      n_cmp++; if ({bus.rvalid, bus.rlast, bus.rid} !== {(k < 4), (k >= 2 && k < 4), (k < 4) ? 4'd2 : 4'd2}) begin
        n_err++; $display("FAIL bp_rd_k%0d: got v=%b last=%b id=%0d want %0d/%0d/2", k, bus.rvalid, bus.rlast, bus.rid, (k < 4), (k >= 2 && k < 4)); end
      bus.rready = k[0];
      if (bus.rvalid && bus.rready) beats++;
      @(negedge clk);
    end
    bus.rready = 0;
    n_cmp++; if (beats !== 2) begin n_err++; $display("FAIL bp_rd_beats: got %0d want 2", beats); end

    bus.awvalid = 1; bus.awid = 4'd6; bus.awlen = 8'd0; bus.bready = 0;
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 1; bus.wlast = 1;
    @(negedge clk);
    bus.wvalid = 0; bus.wlast = 0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if ({bus.bvalid, bus.bid, bus.bresp} !== {1'b1, 4'd6, 2'b11}) begin
        n_err++; $display("FAIL bp_b_stall%0d: got %b/%0d/%b want 1/6/11", k, bus.bvalid, bus.bid, bus.bresp); end
      @(negedge clk);
    end
    bus.bready = 1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_cmp++; if (bus.bvalid !== 1'b0) begin n_err++; $display("FAIL bp_b_dup%0d: got %b want 0", k, bus.bvalid); end
      @(negedge clk);
    end
  endtask

  task automatic test_wlast_mismatch();
    bus.bready = 1;
    bus.awvalid = 1; bus.awid = 4'd7; bus.awlen = 8'd2;
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 1; bus.wlast = 0;
    #1;
    n_cmp++; if (wlast_err !== 1'b0) begin n_err++; $display("FAIL wm_early_b0: got %b want 0", wlast_err); end
    @(negedge clk);
    bus.wlast = 1;
    #1;
    n_cmp++; if (wlast_err !== 1'b1) begin n_err++; $display("FAIL wm_early_b1: got %b want 1", wlast_err); end
    @(negedge clk);
    bus.wvalid = 0; bus.wlast = 0;
    #1;
    n_cmp++; if ({bus.bvalid, bus.wready, wlast_err} !== 3'b100) begin
      n_err++; $display("FAIL wm_early_b: got %b want 100", {bus.bvalid, bus.wready, wlast_err}); end
    @(negedge clk);

    bus.awvalid = 1; bus.awid = 4'd8; bus.awlen = 8'd1;
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 1; bus.wlast = 0;
    #1;
    n_cmp++; if (wlast_err !== 1'b0) begin n_err++; $display("FAIL wm_miss_b0: got %b want 0", wlast_err); end
    @(negedge clk);
    #1;
    n_cmp++; if (wlast_err !== 1'b1) begin n_err++; $display("FAIL wm_miss_b1: got %b want 1", wlast_err); end
    @(negedge clk);
    bus.wvalid = 0;
    n_cmp++; if ({bus.bvalid, bus.bid, bus.wready} !== {1'b1, 4'd8, 1'b0}) begin
      n_err++; $display("FAIL wm_miss_b: got %b/%0d/%b want 1/8/0", bus.bvalid, bus.bid, bus.wready); end
    @(negedge clk);
  endtask

  task automatic test_concurrent_long();
    int rbeats = 0;
    int nlast  = 0;
    int lastpos = -1;
    int bseen  = 0;
    bus.awvalid = 1; bus.awid = 4'd2; bus.awlen = 8'd0; bus.awaddr = 32'h0000_AAA0;
    bus.arvalid = 1; bus.arid = 4'd4; bus.arlen = 8'd255; bus.araddr = 32'h0000_BBB0;
    bus.rready = 1; bus.bready = 1;
    @(negedge clk);
    bus.awvalid = 0; bus.arvalid = 0;
    n_cmp++; if (last_addr !== 32'h0000_BBB0) begin n_err++; $display("FAIL cc_addr: got %0h want bbb0", last_addr); end
    bus.wvalid = 1; bus.wlast = 1;
    for (int c = 0; c < 300; c++) begin
      if (bus.rvalid) begin
        if (bus.rlast) begin nlast++; lastpos = rbeats; end
        rbeats++;
      end
      if (bus.bvalid) bseen++;
      if (c == 1) begin bus.wvalid = 0; bus.wlast = 0; end
      @(negedge clk);
    end
    n_cmp++; if (rbeats !== 256) begin n_err++; $display("FAIL cc_rbeats: got %0d want 256", rbeats); end
    n_cmp++; if (nlast !== 1 || lastpos !== 255) begin
      n_err++; $display("FAIL cc_rlast: got count=%0d pos=%0d want 1/255", nlast, lastpos); end
    n_cmp++; if (bseen !== 1) begin n_err++; $display("FAIL cc_bcount: got %0d want 1", bseen); end
  endtask

  task automatic test_reset_mid_burst();
    bus.bready = 0;
    bus.awvalid = 1; bus.awid = 4'd9; bus.awlen = 8'd0;
    @(negedge clk);
    bus.awvalid = 0; bus.wvalid = 1; bus.wlast = 1;
    @(negedge clk);
    bus.wvalid = 0; bus.wlast = 0;
    n_cmp++; if (bus.bvalid !== 1'b1) begin n_err++; $display("FAIL rm_bpend: got %b want 1", bus.bvalid); end
    bus.arvalid = 1; bus.arid = 4'd3; bus.arlen = 8'd7; bus.araddr = 32'h3000_0000; bus.rready = 1;
    @(negedge clk);
    bus.arvalid = 0;
    @(negedge clk);
    n_cmp++; if ({bus.rvalid, bus.rlast} !== 2'b10) begin n_err++; $display("FAIL rm_beat2: got %b want 10", {bus.rvalid, bus.rlast}); end
    rst = 1;
    #1;
    n_cmp++; if ({bus.rvalid, bus.bvalid, bus.arready, bus.awready} !== 4'b0) begin
      n_err++; $display("FAIL rm_async: got %b want 0000", {bus.rvalid, bus.bvalid, bus.arready, bus.awready}); end
    n_cmp++; if (last_addr !== '0) begin n_err++; $display("FAIL rm_addr: got %0h want 0", last_addr); end
    @(negedge clk);
    rst = 0;
    bus.bready = 1;
    #1;
    n_cmp++; if (bus.arready !== 1'b0) begin n_err++; $display("FAIL rm_rel: got %b want 0", bus.arready); end
    @(negedge clk);
    n_cmp++; if ({bus.arready, bus.awready, bus.rvalid, bus.bvalid} !== 4'b1100) begin
      n_err++; $display("FAIL rm_after: got %b want 1100", {bus.arready, bus.awready, bus.rvalid, bus.bvalid}); end
    bus.arvalid = 1; bus.arid = 4'd1; bus.arlen = 8'd0;
    @(negedge clk);
    bus.arvalid = 0;
    n_cmp++; if ({bus.rvalid, bus.rid, bus.rlast, bus.rresp} !== {1'b1, 4'd1, 1'b1, 2'b11}) begin
      n_err++; $display("FAIL rm_fresh: got %b/%0d/%b/%b want 1/1/1/11", bus.rvalid, bus.rid, bus.rlast, bus.rresp); end
    @(negedge clk);
    n_cmp++; if ({bus.rvalid, bus.arready, bus.bvalid} !== 3'b010) begin
      n_err++; $display("FAIL rm_fresh_end: got %b want 010", {bus.rvalid, bus.arready, bus.bvalid}); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_single();
    test_read_burst();
    test_backpressure();
    test_wlast_mismatch();
    test_concurrent_long();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
